// File: rtl/prbs_err_led_bank.sv
// Multi-lane PRBS error indicator: per-lane saturating error counter, OFF/SOLID/BLINK FSM and LED drive.
// Optional macro PRBS_ERR_CNT_EN adds the registered err_cnt output carrying every lane's count.
module prbs_err_led_bank #(
    parameter int CHANNELS     = 4,
    parameter int CNT_W        = 8,
    parameter int BLINK_THRESH = 2,
    parameter int BLINK_HALF   = 12500000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic [CHANNELS-1:0]       err_in,
`ifdef PRBS_ERR_CNT_EN
    output logic [CHANNELS*CNT_W-1:0] err_cnt,
`endif
    output logic [CHANNELS-1:0]       led,
    output logic                      any_err,
    output logic                      blink_phase
);

    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] THRESH     = CNT_W'(BLINK_THRESH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SOLID = 2'd1,
        BLINK = 2'd2
    } state_t;

    // state_q is the per-lane FSM state; kept as a plain array so checkers can bind to it.
    state_t           state_q [CHANNELS];
    logic [CNT_W-1:0] cnt_q   [CHANNELS];
    logic [CNT_W-1:0] cnt_inc [CHANNELS];
    logic [CHANNELS-1:0] active;
    logic [BW-1:0]       blink_cnt;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_inc[i] = (cnt_q[i] == CNT_MAX) ? CNT_MAX : cnt_q[i] + CNT_W'(1);
            active[i]  = (state_q[i] != IDLE);
        end
    end

    // Free-running blink generator; deliberately not affected by clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]   <= '0;
                state_q[i] <= IDLE;
            end
            led     <= '0;
            any_err <= 1'b0;
`ifdef PRBS_ERR_CNT_EN
            err_cnt <= '0;
`endif
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (clear) begin
                    cnt_q[i]   <= '0;
                    state_q[i] <= IDLE;
                end else begin
                    if (err_in[i]) begin
                        cnt_q[i] <= cnt_inc[i];
                    end
                    // Threshold is judged on the count including this cycle's error.
                    case (state_q[i])
                        IDLE, SOLID: begin
                            if (err_in[i]) begin
                                state_q[i] <= (cnt_inc[i] >= THRESH) ? BLINK : SOLID;
                            end
                        end
                        BLINK:   state_q[i] <= BLINK;
                        default: state_q[i] <= IDLE;
                    endcase
                end

                case (state_q[i])
                    SOLID:   led[i] <= 1'b1;
                    BLINK:   led[i] <= blink_phase;
                    default: led[i] <= 1'b0;
                endcase
`ifdef PRBS_ERR_CNT_EN
                err_cnt[i*CNT_W +: CNT_W] <= cnt_q[i];
`endif
            end
            any_err <= |active;
        end
    end

endmodule
